// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that feeds bytes from four requesters into a single
// UART transmitter, with a start handshake timeout and an inter-frame gap.
module uart_tx_scheduler #(
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  req_i,
  input  logic [31:0] req_data_i,
  output logic [3:0]  ack_o,
  output logic        tx_write_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  output logic [1:0]  cur_id_o,
  output logic        busy_o,
  output logic        err_timeout_o
);

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int DW      = 8;
  localparam int unsigned CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  // Last count value of each phase; a zero gap still spends one cycle in GAP.
  localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, GAP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gnt_q, gnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_write_q, tx_write_d;
  logic [DW-1:0]        tx_data_q, tx_data_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0][DW-1:0] lane_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = req_data_i[g*DW +: DW];
  end

  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;

  // Walk offsets from far to near so the requester closest to ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    cand    = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + IDW'(k);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    tx_write_d = tx_write_q;
    tx_data_d  = tx_data_q;
    cur_id_d   = cur_id_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d   = win_id;
          ptr_d   = win_id + 2'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // A requester that withdrew since the decision is simply skipped.
        if (req_i[gnt_q]) begin
          tx_data_d    = lane_data[gnt_q];
          cur_id_d     = gnt_q;
          ack_d[gnt_q] = 1'b1;
          tx_write_d   = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT_START;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_START: begin
        if (tx_busy_i) begin
          tx_write_d = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_DONE;
        end else if (cnt_q >= TO_LAST) begin
          err_d      = 1'b1;
          tx_write_d = 1'b0;
          cnt_d      = '0;
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_write_q <= 1'b0;
      tx_data_q  <= 8'h00;
      cur_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
      cur_id_q   <= cur_id_d;
      err_q      <= err_d;
    end
  end

  assign ack_o         = ack_q;
  assign tx_write_o    = tx_write_q;
  assign tx_data_o     = tx_data_q;
  assign cur_id_o      = cur_id_q;
  assign busy_o        = (state_q != IDLE);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: scoreboard of expected grants checked
// on every ack pulse, plus timing checks on latency, timeout and gap lengths.
module tb_uart_tx_scheduler;

  localparam int GAP = 16;
  localparam int TO  = 255;
  localparam int TO0 = 8;

  logic        clk, rst_n;
  logic [3:0]  req, ack;
  logic [31:0] req_data;
  logic        tx_write, tx_busy, busy, err;
  logic [7:0]  tx_data;
  logic [1:0]  cur_id;

  logic [3:0]  req0, ack0;
  logic [31:0] req_data0;
  logic        tx_write0, tx_busy0, busy0, err0;
  logic [7:0]  tx_data0;
  logic [1:0]  cur_id0;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;
  exp_t sb[$];

  uart_tx_scheduler #(.GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_data_i(req_data),
    .ack_o(ack), .tx_write_o(tx_write), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
    .cur_id_o(cur_id), .busy_o(busy), .err_timeout_o(err));

  uart_tx_scheduler #(.GAP_CYCLES(0), .START_TIMEOUT(TO0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .req_data_i(req_data0),
    .ack_o(ack0), .tx_write_o(tx_write0), .tx_data_o(tx_data0), .tx_busy_i(tx_busy0),
    .cur_id_o(cur_id0), .busy_o(busy0), .err_timeout_o(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0: return tx_write === 1'b1;
      1: return err === 1'b1;
      2: return busy === 1'b0;
      3: return tx_write0 === 1'b1;
      4: return err0 === 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  // Counts falling edges until the selected condition holds, bounded.
  task automatic wait_for(input string tag, input int sel, output int n);
    n = 0;
    while (!probe(sel) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, 32'(n < 1000), 32'd1);
  endtask

  function automatic exp_t mk(input logic [1:0] id, input logic [31:0] d);
    exp_t e;
    e.id   = id;
    e.data = d[8*id +: 8];
    return e;
  endfunction

  // Called on the cycle tx_write is first seen high.
  task automatic serve(input int dly, input int len);
    repeat (dly) begin
      tick(1);
      chk("write_held", 32'(tx_write), 32'd1);
    end
    tx_busy = 1'b1;
    tick(1);
    chk("write_drop", 32'(tx_write), 32'd0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    tick(len - 1);
    tx_busy = 1'b0;
  endtask

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (ack !== 4'b0) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_onehot", 32'(ack), 32'(4'b0001 << e.id));
        chk("ack_tx_data", 32'(tx_data), 32'(e.data));
        chk("ack_cur_id", 32'(cur_id), 32'(e.id));
        chk("ack_tx_write", 32'(tx_write), 32'd1);
      end
    end
  end

  initial begin
    int n;
    logic [1:0] order [7];
    order = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
    req0 = '0; req_data0 = '0; tx_busy0 = 1'b0;
    tick(3);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_write", 32'(tx_write), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_id", 32'(cur_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single requester, transmitter starts 3 cycles after the strobe.
    req = 4'b0001; req_data = 32'h112233A5;
    sb.push_back(mk(2'd0, req_data));
    tick(1);
    chk("lat_ack_early", 32'(ack), 32'd0);
    chk("lat_write_early", 32'(tx_write), 32'd0);
    chk("lat_busy_load", 32'(busy), 32'd1);
    tick(1);
    chk("lat_write", 32'(tx_write), 32'd1);
    req = '0;
    serve(3, 10);
    chk("hold_data", 32'(tx_data), 32'hA5);
    wait_for("idle1", 2, n);
    chk("gap_to_idle", 32'(n), 32'(GAP + 1));

    // Transmitter never starts: timeout, byte dropped, ptr moves to 3.
    req = 4'b0100; req_data = 32'h003C0000;
    sb.push_back(mk(2'd2, req_data));
    wait_for("w2", 0, n);
    chk("lat2", 32'(n), 32'd2);
    req = '0;
    wait_for("to", 1, n);
    chk("timeout_cycles", 32'(n), 32'(TO));
    chk("to_write_low", 32'(tx_write), 32'd0);
    chk("to_busy", 32'(busy), 32'd1);
    wait_for("idle2", 2, n);
    chk("to_gap", 32'(n), 32'(GAP));
    chk("err_once", 32'(err_cnt), 32'd1);

    // All four requesting; first frame starts on the exact expiry cycle.
    req = 4'b1111; req_data = 32'hD4C3B2A1;
    for (int i = 0; i < 7; i++) sb.push_back(mk(order[i], req_data));
    wait_for("w3", 0, n);
    chk("lat3", 32'(n), 32'd2);
    tick(TO - 1);
    tx_busy = 1'b1;
    tick(1);
    chk("exp_write_low", 32'(tx_write), 32'd0);
    chk("exp_no_err", 32'(err), 32'd0);
    chk("exp_wait_done", 32'(busy), 32'd1);
    tick(5);
    tx_busy = 1'b0;
    chk("exp_err_cnt", 32'(err_cnt), 32'd1);
    for (int f = 1; f < 7; f++) begin
      wait_for("wf", 0, n);
      chk("frame_gap", 32'(n), 32'(GAP + 3));
      if (f < 6) serve(3, 10);
    end

    // Reset in WAIT_DONE of the requester-1 frame.
    tick(3);
    tx_busy = 1'b1;
    tick(3);
    chk("wd_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack", 32'(ack), 32'd0);
    chk("mid_write", 32'(tx_write), 32'd0);
    chk("mid_data", 32'(tx_data), 32'd0);
    chk("mid_id", 32'(cur_id), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    tick(1);
    tx_busy = 1'b0;
    req = 4'b0100;
    sb.push_back(mk(2'd2, req_data));
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rel_ack", 32'(ack), 32'd0);
    chk("rel_write", 32'(tx_write), 32'd0);
    tick(1);
    chk("rel_write_hi", 32'(tx_write), 32'd1);
    req = '0;
    serve(2, 4);
    wait_for("idle4", 2, n);
    chk("idle4_gap", 32'(n), 32'(GAP + 1));

    // After granting 2 the pointer sits at 3.
    req = 4'b1111;
    sb.push_back(mk(2'd3, req_data));
    wait_for("w5", 0, n);
    req = '0;
    serve(2, 4);
    wait_for("idle5", 2, n);
    chk("err_total", 32'(err_cnt), 32'd1);

    // Zero-gap instance, requester 1 re-requests straight after ack.
    req0 = 4'b0010; req_data0 = 32'h00005A00;
    wait_for("d0w1", 3, n);
    chk("d0_lat", 32'(n), 32'd2);
    chk("d0_ack1", 32'(ack0), 32'h2);
    chk("d0_data1", 32'(tx_data0), 32'h5A);
    chk("d0_id1", 32'(cur_id0), 32'd1);
    req_data0 = 32'h00006B00;
    tick(2);
    tx_busy0 = 1'b1;
    tick(1);
    chk("d0_write_drop", 32'(tx_write0), 32'd0);
    chk("d0_ack_gone", 32'(ack0), 32'd0);
    tick(4);
    tx_busy0 = 1'b0;
    wait_for("d0w2", 3, n);
    chk("d0_gap", 32'(n), 32'd4);
    chk("d0_ack2", 32'(ack0), 32'h2);
    chk("d0_data2", 32'(tx_data0), 32'h6B);
    req0 = '0;
    wait_for("d0to", 4, n);
    chk("d0_timeout", 32'(n), 32'(TO0));
    chk("d0_to_write", 32'(tx_write0), 32'd0);
    tick(1);
    chk("d0_err_pulse", 32'(err0), 32'd0);

    tick(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
